harmonic_bin_extract: RTL
=========================

Name: harmonic_bin_extract

Overview:
- Downstream consumer of the FFT power stage. Takes one frame per sop..eop of 24-bit |X|² values, buffers the frame in on-chip RAM and finds the fundamental (peak) bin in the first half-spectrum.
- After the frame, reads back the power at bins k·f for k = 1..NH and streams them out for THD computation.

Parameters:
- N, 1024, FFT length (power of 2); bin counter width AW = log2(N).
- DW, 24, input power width.
- NH, 5, harmonics reported, including the fundamental (k=1).
- DC_SKIP, 2, lowest bin eligible for the peak search (bins 0..DC_SKIP-1 excluded).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_sop  in  1  first bin of a frame; in_data valid this cycle.
- in_eop  in  1  last bin of a frame.
- in_data  in  DW  bin power; valid on every cycle from in_sop through in_eop inclusive.
- busy  out  1  high from accepted in_sop until the cycle after the last h_valid.
- h_valid  out  1  one harmonic result this cycle.
- h_idx  out  3  harmonic number k (1..NH).
- h_bin  out  AW  bin index k·f.
- h_pwr  out  DW+2  power at h_bin, zero-extended.
- h_oob  out  1  k·f ≥ N/2; h_pwr forced to 0.
- h_last  out  1  qualifies the k=NH result.
- frm_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset, synchronous: all outputs 0; state IDLE; bin counter, peak registers and k counter cleared. Reset in any state aborts the frame and emits no outputs.
- IDLE → CAPTURE on in_sop. Bin counter starts at 0 on the sop cycle. Each cycle writes in_data to RAM[cnt] and increments cnt.
- Peak search runs on the fly during capture over bins DC_SKIP..N/2-1:
  - Strictly-greater compare, so ties keep the lowest bin.
  - If no eligible bin exceeds 0, f = DC_SKIP.
- CAPTURE events:
  - in_eop with cnt = N-1 → READ.
  - in_eop with cnt ≠ N-1 → frm_err pulse, go to IDLE.
  - cnt reaches N-1 without in_eop → frm_err pulse, go to IDLE.
  - in_sop while in CAPTURE → restart the frame at bin 0; no frm_err.
  - in_sop and in_eop in the same cycle → treated as a short frame; frm_err.
- READ: harmonic bin is formed by accumulation (addr += f), with no multiplier.
  - RAM has 1-cycle read latency; outputs are registered.
  - First h_valid (k=1) occurs exactly 3 cycles after the eop cycle, then one result per cycle, NH consecutive cycles; h_last accompanies k=NH.
  - Accumulator is AW+3 bits wide. If the accumulated bin is ≥ N/2, h_oob=1 and h_pwr=0; h_bin carries the low AW bits.
- The cycle after h_last, busy drops and the state returns to IDLE.
- in_sop/in_eop during READ are ignored: no RAM write, no frm_err. The next frame is accepted only from IDLE, which is reachable on the cycle after h_last.
- h_valid, h_last and frm_err are single-cycle pulses. h_idx/h_bin/h_pwr/h_oob hold their last value when h_valid=0.

Optional Feature:
- Macro LEAKAGE_SUM_EN.
- Defined: h_pwr = RAM[b-1] + RAM[b] + RAM[b+1] (DW+2 bits, no overflow possible).
  - Neighbours outside 0..N/2-1 contribute 0.
  - Three reads per harmonic, so results come every 3rd cycle. First h_valid is 5 cycles after eop. busy is extended accordingly.
- Undefined: single-bin read, 1 result/cycle, timing as above.

Test Plan:
- N=64, NH=5. Frame all 0 except bin5=1000, 10=200, 15=50, 20=10, 25=5; eop at bin 63 → h_valid at eop+3..+7, (k,bin,pwr) = (1,5,1000), (2,10,200), (3,15,50), (4,20,10), (5,25,5); h_last with k=5; h_oob=0 throughout.
- N=64, peak bin8=500, bin1=900 (DC-excluded) → f=8. Bins 8,16,24 in range; bins 32,40 give h_oob=1, h_pwr=0.
- Tie: bin6=bin12=700 → f=6. k=2 reports bin12=700.
- Short frame: eop at bin 40 → frm_err pulse at eop+1, no h_valid. Next full frame is processed normally.
- sop during READ ignored, with results unchanged; sop mid-CAPTURE restarts the frame; rst asserted mid-READ → all outputs 0 next cycle, no further h_valid.
- LEAKAGE_SUM_EN defined: bins 4/5/6 = 100/1000/100 → k=1 h_pwr=1200 at eop+5, next result 3 cycles later.

Source files
------------

// File: rtl/harmonic_bin_extract.sv
// Frame buffer plus peak-bin search, then streams the power at k*f for k = 1..NH.
// Define LEAKAGE_SUM_EN to report the three-bin leakage sum around each harmonic.
module harmonic_bin_extract #(
    parameter int N       = 1024,
    parameter int DW      = 24,
    parameter int NH      = 5,
    parameter int DC_SKIP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [DW-1:0]         in_data,
    output logic                  busy,
    output logic                  h_valid,
    output logic [2:0]            h_idx,
    output logic [$clog2(N)-1:0]  h_bin,
    output logic [DW+1:0]         h_pwr,
    output logic                  h_oob,
    output logic                  h_last,
    output logic                  frm_err
);
    localparam int AW  = $clog2(N);
    localparam int ACW = AW + 3;
`ifdef LEAKAGE_SUM_EN
    localparam int NSUB = 3;
`else
    localparam int NSUB = 1;
`endif
    localparam int OFS = (NSUB - 1) / 2;
    localparam logic [AW-1:0]  LAST_BIN = AW'(N - 1);
    localparam logic [AW-1:0]  HALF_BIN = AW'(N / 2);
    localparam logic [ACW-1:0] HALF_ACC = ACW'(N / 2);
    localparam logic [AW-1:0]  DC_BIN   = AW'(DC_SKIP);

    typedef enum logic [1:0] {IDLE, CAPTURE, READ} state_t;

    typedef struct packed {
        logic          valid;
        logic          en;
        logic          first;
        logic          last;
        logic          last_k;
        logic [2:0]    k;
        logic [AW-1:0] bin;
        logic          oob;
    } tap_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   peak_bin_q, peak_bin_d;
    logic [DW-1:0]   peak_pwr_q, peak_pwr_d;
    logic [ACW-1:0]  acc_q, acc_d;
    logic [2:0]      k_q, k_d;
    logic [1:0]      sub_q, sub_d;
    logic            iss_q, iss_d;
    tap_t            a_q, a_d, b_q;
    logic [AW-1:0]   a_addr_q, a_addr_d;
    logic [DW+1:0]   sum_q, sum_d;
    logic            h_valid_q, h_valid_d, h_last_q, h_last_d, h_oob_q, h_oob_d;
    logic            frm_err_q, frm_err_d;
    logic [2:0]      h_idx_q, h_idx_d;
    logic [AW-1:0]   h_bin_q, h_bin_d;
    logic [DW+1:0]   h_pwr_q, h_pwr_d;

    logic [DW-1:0]   mem [N];
    logic [DW-1:0]   ram_q;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            start_read, issue;
    logic [ACW-1:0]  iss_acc;
    logic [1:0]      iss_sub;
    logic [2:0]      iss_k;
    logic [ACW:0]    tap;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        peak_bin_d = peak_bin_q;
        peak_pwr_d = peak_pwr_q;
        frm_err_d  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = cnt_q;
        start_read = 1'b0;

        if (state_q == IDLE || state_q == CAPTURE) begin
            if (in_sop) begin
                wr_en      = 1'b1;
                wr_addr    = '0;
                cnt_d      = AW'(1);
                peak_bin_d = DC_BIN;
                peak_pwr_d = '0;
                if (DC_SKIP == 0 && in_data != '0) begin
                    peak_bin_d = '0;
                    peak_pwr_d = in_data;
                end
                if (in_eop) begin
                    frm_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end else if (state_q == CAPTURE) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + AW'(1);
                // Strict compare keeps the lowest bin on ties.
                if (cnt_q >= DC_BIN && cnt_q < HALF_BIN && in_data > peak_pwr_q) begin
                    peak_bin_d = cnt_q;
                    peak_pwr_d = in_data;
                end
                if (in_eop && cnt_q == LAST_BIN) begin
                    start_read = 1'b1;
                    state_d    = READ;
                end else if (in_eop || cnt_q == LAST_BIN) begin
                    frm_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
        end else if (state_q != READ) begin
            state_d = IDLE;
        end else if (h_valid_q && h_last_q) begin
            state_d = IDLE;
        end

        // The first read is issued on the eop edge itself, straight from the peak bin.
        issue   = start_read || (state_q == READ && iss_q);
        iss_acc = (state_q == READ) ? acc_q : {3'b000, peak_bin_q};
        iss_sub = (state_q == READ) ? sub_q : 2'd0;
        iss_k   = (state_q == READ) ? k_q : 3'd1;
        tap     = {1'b0, iss_acc} + (ACW+1)'(iss_sub);

        acc_d = acc_q;
        k_d   = k_q;
        sub_d = sub_q;
        iss_d = iss_q;
        if (issue) begin
            if (iss_sub == 2'(NSUB - 1)) begin
                sub_d = 2'd0;
                acc_d = iss_acc + {3'b000, peak_bin_q};
                k_d   = iss_k + 3'd1;
                iss_d = (iss_k != 3'(NH));
            end else begin
                sub_d = iss_sub + 2'd1;
                acc_d = iss_acc;
                k_d   = iss_k;
                iss_d = 1'b1;
            end
        end

        a_d.valid  = issue;
        a_d.en     = (tap >= (ACW+1)'(OFS)) && ((tap - (ACW+1)'(OFS)) < (ACW+1)'(N / 2));
        a_d.first  = (iss_sub == 2'd0);
        a_d.last   = (iss_sub == 2'(NSUB - 1));
        a_d.last_k = (iss_k == 3'(NH));
        a_d.k      = iss_k;
        a_d.bin    = iss_acc[AW-1:0];
        a_d.oob    = (iss_acc >= HALF_ACC);
        a_addr_d   = AW'(tap - (ACW+1)'(OFS));

        sum_d     = sum_q;
        h_valid_d = 1'b0;
        h_last_d  = 1'b0;
        h_idx_d   = h_idx_q;
        h_bin_d   = h_bin_q;
        h_pwr_d   = h_pwr_q;
        h_oob_d   = h_oob_q;
        if (b_q.valid) begin
            sum_d = (b_q.first ? '0 : sum_q) + (b_q.en ? {2'b00, ram_q} : '0);
            if (b_q.last) begin
                h_valid_d = 1'b1;
                h_last_d  = b_q.last_k;
                h_idx_d   = b_q.k;
                h_bin_d   = b_q.bin;
                h_oob_d   = b_q.oob;
                h_pwr_d   = b_q.oob ? '0 : sum_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            peak_bin_q <= '0;
            peak_pwr_q <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            sub_q      <= '0;
            iss_q      <= 1'b0;
            a_q        <= '0;
            a_addr_q   <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            h_valid_q  <= 1'b0;
            h_last_q   <= 1'b0;
            h_idx_q    <= '0;
            h_bin_q    <= '0;
            h_pwr_q    <= '0;
            h_oob_q    <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            peak_bin_q <= peak_bin_d;
            peak_pwr_q <= peak_pwr_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            sub_q      <= sub_d;
            iss_q      <= iss_d;
            a_q        <= a_d;
            a_addr_q   <= a_addr_d;
            b_q        <= a_q;
            sum_q      <= sum_d;
            h_valid_q  <= h_valid_d;
            h_last_q   <= h_last_d;
            h_idx_q    <= h_idx_d;
            h_bin_q    <= h_bin_d;
            h_pwr_q    <= h_pwr_d;
            h_oob_q    <= h_oob_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // Frame RAM: one write port, registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
        ram_q <= mem[a_addr_q];
    end

    assign busy    = (state_q != IDLE);
    assign h_valid = h_valid_q;
    assign h_last  = h_last_q;
    assign h_idx   = h_idx_q;
    assign h_bin   = h_bin_q;
    assign h_pwr   = h_pwr_q;
    assign h_oob   = h_oob_q;
    assign frm_err = frm_err_q;

endmodule
